ground_scroller: RTL and testbench

Parametrised scrolling-ground renderer for the VGA game display. It stores a ROWS × TILE_W bitmap tile written by the host logic, repeats it horizontally across a fixed scanline band, and advances the scroll offset once per video frame while the game runs. It also supports pause and an optional per-frame speed ramp. It sits between the VGA sync generator (row/column address, frame tick) and the pixel mixer, alongside the dinosaur and obstacle renderers.

---
 rtl/ground_scroller.sv | 201 ++++++++++++++++++++
 tb/tb_ground_scroller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ground_scroller.sv
// ---------------------------------------------------------------------------
// ground_scroller
//
// Scrolling-ground renderer for the VGA game display. A ROWS x TILE_W bitmap
// tile, loaded by the host while the game is idle, is repeated horizontally
// across a fixed scanline band [Y_TOP, Y_TOP+ROWS). The tile slides left by
// `speed` pixels on every frame tick while the game runs. Pause freezes the
// scroll without blanking the ground.
//
// Optional feature macro: GROUND_SPEEDUP_EN
//   When defined, a ramp counter counts frame ticks in RUN and bumps the speed
//   by one every RAMP_FRAMES ticks, saturating at SPEED_MAX. When undefined,
//   the speed stays at SPEED_INIT and no ramp counter exists.
//
// Ports
//   i_clk             system clock, all logic on the rising edge
//   i_rst             synchronous reset, active high
//   i_row_addr        current scanline from the sync generator
//   i_col_addr        current pixel column from the sync generator
//   i_frame_tick      single-cycle pulse once per frame (start of vblank)
//   i_game_status     1 = game running, 0 = idle / game over
//   i_pause           level, freezes scrolling while running
//   i_wr_en           tile row write strobe (honoured in IDLE only)
//   i_wr_row          tile row index
//   i_wr_data         tile row contents, bit 0 = leftmost pixel
//   o_ground_position current scroll offset (0..TILE_W-1)
//   o_speed           current pixels per frame
//   o_state           00 IDLE, 01 RUN, 10 PAUSE
//   o_px              registered ground pixel, one cycle after the address
// ---------------------------------------------------------------------------
module ground_scroller #(
    parameter int TILE_W      = 40,
    parameter int ROWS        = 8,
    parameter int Y_TOP       = 400,
    parameter int SPD_W       = 5,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 12,
    parameter int RAMP_FRAMES = 256,
    localparam int POS_W      = $clog2(TILE_W),
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [8:0]        i_row_addr,
    input  logic [9:0]        i_col_addr,
    input  logic              i_frame_tick,
    input  logic              i_game_status,
    input  logic              i_pause,
    input  logic              i_wr_en,
    input  logic [ROW_W-1:0]  i_wr_row,
    input  logic [TILE_W-1:0] i_wr_data,
    output logic [POS_W-1:0]  o_ground_position,
    output logic [SPD_W-1:0]  o_speed,
    output logic [1:0]        o_state,
    output logic              o_px
);

    localparam int SUM_W = POS_W + SPD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t            r_state;
    logic [POS_W-1:0]  r_pos;
    logic [SPD_W-1:0]  r_speed;
    logic              r_px;
    logic [TILE_W-1:0] r_pattern [ROWS];

    logic [SUM_W-1:0]  w_sum;
    logic [8:0]        w_row_off;
    logic              w_in_band;
    logic [POS_W-1:0]  w_col_mod;
    logic [POS_W:0]    w_idx_sum;
    logic [POS_W-1:0]  w_idx;
    logic              w_wr_ok;

`ifdef GROUND_SPEEDUP_EN
    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [SPD_W-1:0]  w_speed_next;

    // Saturating speed increment used when the ramp counter wraps.
    assign w_speed_next = (r_speed >= SPD_W'(SPEED_MAX)) ? r_speed : r_speed + 1'b1;
`endif

    // Next scroll position before the modulo. Both operands are below TILE_W,
    // so one conditional subtract in the FSM brings it back into range.
    assign w_sum = SUM_W'(r_pos) + SUM_W'(r_speed);

    // Band detection and the tile column for the current pixel. The render
    // uses the registered position, so a tick only affects later addresses.
    assign w_row_off = i_row_addr - 9'(Y_TOP);
    assign w_in_band = (i_row_addr >= 9'(Y_TOP)) && (w_row_off < 9'(ROWS));
    assign w_col_mod = POS_W'(i_col_addr % 10'(TILE_W));
    assign w_idx_sum = {1'b0, w_col_mod} + {1'b0, r_pos};
    assign w_idx     = (w_idx_sum >= (POS_W+1)'(TILE_W))
                       ? POS_W'(w_idx_sum - (POS_W+1)'(TILE_W))
                       : POS_W'(w_idx_sum);

    // Tile writes only land while idle and only for rows that exist.
    assign w_wr_ok = i_wr_en && (r_state == IDLE) && (int'(i_wr_row) < ROWS);

    // Game FSM: owns the state, scroll offset, speed and (optionally) the
    // ramp counter. Dropping game_status always wins, even over a tick or
    // pause arriving in the same cycle. A held pause also masks ticks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pos      <= '0;
            r_speed    <= SPD_W'(SPEED_INIT);
`ifdef GROUND_SPEEDUP_EN
            r_ramp_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_pos      <= '0;
                    r_speed    <= SPD_W'(SPEED_INIT);
`ifdef GROUND_SPEEDUP_EN
                    r_ramp_cnt <= '0;
`endif
                    if (i_game_status) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!i_game_status) begin
                        r_state    <= IDLE;
                        r_pos      <= '0;
                        r_speed    <= SPD_W'(SPEED_INIT);
`ifdef GROUND_SPEEDUP_EN
                        r_ramp_cnt <= '0;
`endif
                    end else if (i_pause) begin
                        r_state <= PAUSE;
                    end else if (i_frame_tick) begin
                        r_pos <= (w_sum >= SUM_W'(TILE_W))
                                 ? POS_W'(w_sum - SUM_W'(TILE_W))
                                 : POS_W'(w_sum);
`ifdef GROUND_SPEEDUP_EN
                        if (r_ramp_cnt == RAMP_W'(RAMP_FRAMES - 1)) begin
                            r_ramp_cnt <= '0;
                            r_speed    <= w_speed_next;
                        end else begin
                            r_ramp_cnt <= r_ramp_cnt + 1'b1;
                        end
`endif
                    end
                end
                PAUSE: begin
                    if (!i_game_status) begin
                        r_state    <= IDLE;
                        r_pos      <= '0;
                        r_speed    <= SPD_W'(SPEED_INIT);
`ifdef GROUND_SPEEDUP_EN
                        r_ramp_cnt <= '0;
`endif
                    end else if (!i_pause) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Tile storage. Reset wipes the pattern; a write becomes visible to the
    // render path on the following cycle, so a same-cycle read sees old data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ROWS; i++) begin
                r_pattern[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_pattern[i_wr_row] <= i_wr_data;
        end
    end

    // Pixel output register: one cycle of latency from the address inputs,
    // blank outside the ground band.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_px <= 1'b0;
        end else if (w_in_band) begin
            r_px <= r_pattern[ROW_W'(w_row_off)][w_idx];
        end else begin
            r_px <= 1'b0;
        end
    end

    assign o_ground_position = r_pos;
    assign o_speed           = r_speed;
    assign o_state           = r_state;
    assign o_px              = r_px;

endmodule

// File: tb/tb_ground_scroller.sv
// ---------------------------------------------------------------------------
// tb_ground_scroller
//
// Directed bench for ground_scroller with TILE_W=40, ROWS=8, Y_TOP=400,
// SPEED_INIT=4, SPEED_MAX=6, RAMP_FRAMES=4. Builds with or without
// GROUND_SPEEDUP_EN; the expected speed sequence follows the build.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same moment, reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_ground_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  rowAddr;
    logic [9:0]  colAddr;
    logic        frameTick;
    logic        gameStatus;
    logic        pause;
    logic        wrEn;
    logic [2:0]  wrRow;
    logic [39:0] wrData;
    logic [5:0]  groundPosition;
    logic [4:0]  speed;
    logic [1:0]  state;
    logic        px;

    int errors = 0;
    int checks = 0;
    int expPos;
    int expSpeed;
    int expCnt;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    ground_scroller #(
        .TILE_W(40), .ROWS(8), .Y_TOP(400), .SPD_W(5),
        .SPEED_INIT(4), .SPEED_MAX(6), .RAMP_FRAMES(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_row_addr(rowAddr),
        .i_col_addr(colAddr),
        .i_frame_tick(frameTick),
        .i_game_status(gameStatus),
        .i_pause(pause),
        .i_wr_en(wrEn),
        .i_wr_row(wrRow),
        .i_wr_data(wrData),
        .o_ground_position(groundPosition),
        .o_speed(speed),
        .o_state(state),
        .o_px(px)
    );

    // One comparison: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel address and take one edge so px reflects it.
    task automatic applyStimulus(input int row, input int col);
        rowAddr = 9'(row);
        colAddr = 10'(col);
        stepClock();
    endtask

    task automatic writeRow(input int row, input logic [39:0] data);
        wrEn   = 1'b1;
        wrRow  = 3'(row);
        wrData = data;
        stepClock();
        wrEn   = 1'b0;
    endtask

    // Reference scroll/ramp behaviour: position uses the speed before any
    // increment caused by the same tick.
    task automatic frameTickPulse(input bit running);
        frameTick = 1'b1;
        stepClock();
        frameTick = 1'b0;
        if (running) begin
            expPos = (expPos + expSpeed) % 40;
`ifdef GROUND_SPEEDUP_EN
            if (expCnt == 3) begin
                expCnt = 0;
                if (expSpeed < 6) expSpeed++;
            end else begin
                expCnt++;
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; rowAddr = '0; colAddr = '0; frameTick = 1'b0;
        gameStatus = 1'b0; pause = 1'b0; wrEn = 1'b0; wrRow = '0; wrData = '0;
        expPos = 0; expSpeed = 4; expCnt = 0;

        stepClock();
        stepClock();
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_pos", 32'(groundPosition), 0);
        checkOutput("reset_speed", 32'(speed), 4);
        checkOutput("reset_px", 32'(px), 0);
        rst = 1'b0;

        // Load tile while idle: row 2 solid, row 0 single pixel at column 5.
        writeRow(2, {40{1'b1}});
        writeRow(0, 40'h20);

        applyStimulus(400, 5);   checkOutput("idle_r400_c5", 32'(px), 1);
        applyStimulus(400, 4);   checkOutput("idle_r400_c4", 32'(px), 0);
        applyStimulus(400, 45);  checkOutput("idle_r400_c45", 32'(px), 1);
        applyStimulus(400, 85);  checkOutput("idle_r400_c85", 32'(px), 1);
        applyStimulus(400, 405); checkOutput("idle_r400_c405", 32'(px), 1);
        applyStimulus(402, 0);   checkOutput("idle_r402_c0", 32'(px), 1);
        applyStimulus(402, 639); checkOutput("idle_r402_c639", 32'(px), 1);
        applyStimulus(399, 10);  checkOutput("above_band", 32'(px), 0);
        applyStimulus(408, 0);   checkOutput("below_band", 32'(px), 0);

        // Same-cycle write and render of row 1: old data first, new next.
        rowAddr = 9'd401; colAddr = 10'd3;
        writeRow(1, {40{1'b1}});
        checkOutput("wr_same_cycle_old", 32'(px), 0);
        applyStimulus(401, 3);   checkOutput("wr_visible_next", 32'(px), 1);

        // Start the game.
        gameStatus = 1'b1;
        stepClock();
        checkOutput("run_state", 32'(state), 1);
        checkOutput("run_pos0", 32'(groundPosition), 0);

        frameTickPulse(1'b1);
        checkOutput("tick1_pos", 32'(groundPosition), 4);
        checkOutput("tick1_speed", 32'(speed), 4);
        applyStimulus(400, 1);   checkOutput("pos4_c1", 32'(px), 1);
        applyStimulus(400, 41);  checkOutput("pos4_c41", 32'(px), 1);
        applyStimulus(400, 5);   checkOutput("pos4_c5", 32'(px), 0);
        frameTickPulse(1'b1);
        checkOutput("tick2_pos", 32'(groundPosition), 8);
        frameTickPulse(1'b1);
        checkOutput("tick3_pos", 32'(groundPosition), 12);
        checkOutput("tick3_speed", 32'(speed), 4);
        checkOutput("tick3_state", 32'(state), 1);

        // Writes are ignored while running.
        writeRow(2, 40'h0);
        applyStimulus(402, 7);   checkOutput("run_write_ignored", 32'(px), 1);

        for (int k = 4; k <= 9; k++) begin
            frameTickPulse(1'b1);
            checkOutput("run_pos_model", 32'(groundPosition), 32'(expPos));
            checkOutput("run_speed_model", 32'(speed), 32'(expSpeed));
        end
`ifndef GROUND_SPEEDUP_EN
        checkOutput("pos36", 32'(groundPosition), 36);
`endif
        frameTickPulse(1'b1);
        checkOutput("tick10_pos", 32'(groundPosition), 32'(expPos));
`ifdef GROUND_SPEEDUP_EN
        checkOutput("tick10_pos_hand", 32'(groundPosition), 8);
`else
        checkOutput("wrap_to_0", 32'(groundPosition), 0);
`endif
        frameTickPulse(1'b1);
        frameTickPulse(1'b1);
        checkOutput("tick12_pos", 32'(groundPosition), 32'(expPos));
`ifdef GROUND_SPEEDUP_EN
        checkOutput("tick12_speed_cap", 32'(speed), 6);
`else
        checkOutput("tick12_speed_const", 32'(speed), 4);
`endif
        applyStimulus(400, (5 - expPos + 40) % 40);
        checkOutput("scrolled_dot", 32'(px), 1);

        // Pause: ticks ignored, rendering continues.
        pause = 1'b1;
        stepClock();
        checkOutput("pause_state", 32'(state), 2);
        for (int k = 0; k < 5; k++) frameTickPulse(1'b0);
        checkOutput("pause_pos_held", 32'(groundPosition), 32'(expPos));
        checkOutput("pause_speed_held", 32'(speed), 32'(expSpeed));
        applyStimulus(402, 0);   checkOutput("pause_px_row2", 32'(px), 1);
        applyStimulus(400, (5 - expPos + 40) % 40);
        checkOutput("pause_px_dot", 32'(px), 1);
        pause = 1'b0;
        stepClock();
        checkOutput("unpause_state", 32'(state), 1);
        frameTickPulse(1'b1);
        checkOutput("unpause_tick_pos", 32'(groundPosition), 32'(expPos));
`ifndef GROUND_SPEEDUP_EN
        checkOutput("unpause_tick_hand", 32'(groundPosition), 12);
`endif

        // game_status drop beats a same-cycle tick.
        frameTick = 1'b1;
        gameStatus = 1'b0;
        stepClock();
        frameTick = 1'b0;
        checkOutput("stop_state", 32'(state), 0);
        checkOutput("stop_pos", 32'(groundPosition), 0);
        checkOutput("stop_speed", 32'(speed), 4);

        // Reset while rendering: px blanks next cycle and the tile is lost.
        applyStimulus(402, 0);   checkOutput("pre_reset_px", 32'(px), 1);
        rst = 1'b1;
        stepClock();
        checkOutput("reset_px_forced", 32'(px), 0);
        rst = 1'b0;
        applyStimulus(402, 0);   checkOutput("pattern_lost", 32'(px), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
